// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access unit: ALU opcodes,
// datapath width, FSM state encoding and byte-enable constants.
package mem_access_unit_pkg;

    localparam int REG_SIZE = 32;

    localparam logic [7:0] ALUOP_LDB = 8'h30;
    localparam logic [7:0] ALUOP_LDW = 8'h31;
    localparam logic [7:0] ALUOP_STB = 8'h32;
    localparam logic [7:0] ALUOP_STW = 8'h33;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE = 2'd0,
        MEM_STATE_BUSY = 2'd1,
        MEM_STATE_DONE = 2'd2
    } memState_e;

    function automatic logic isMemOp(input logic [7:0] op);
        return (op == ALUOP_LDB) || (op == ALUOP_LDW) ||
               (op == ALUOP_STB) || (op == ALUOP_STW);
    endfunction

    function automatic logic isWordOp(input logic [7:0] op);
        return (op == ALUOP_LDW) || (op == ALUOP_STW);
    endfunction

    function automatic logic isLoadOp(input logic [7:0] op);
        return (op == ALUOP_LDB) || (op == ALUOP_LDW);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port. The access unit is the master,
// the memory (or its model) is the slave.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic                req;
    logic                we;
    logic [REG_SIZE-1:0] addr;
    logic [3:0]          be;
    logic [REG_SIZE-1:0] wdata;
    logic                ack;
    logic [REG_SIZE-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/mem_access_unit_load_extract.sv
// Selects the addressed byte lane of a read word and extends it to the
// full register width. Kept separate so unsigned/halfword loads can be
// added later without touching the access FSM.
module mem_access_unit_load_extract
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]          lane_i,
    input  logic [7:0]          op_i,
    input  logic [REG_SIZE-1:0] word_i,
    output logic [REG_SIZE-1:0] data_o
);

    logic [7:0] byteSel;

    // Pick the little-endian byte lane, then sign-extend for byte loads.
    always_comb begin
        byteSel = word_i[8*lane_i +: 8];
        data_o  = word_i;
        if (op_i == ALUOP_LDB) begin
            data_o = {{(REG_SIZE-8){byteSel[7]}}, byteSel};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns a load/store aluop into a single
// req/ack transaction, steers byte lanes, stalls the pipeline while the
// access is outstanding, and reports misaligned word accesses and timeouts.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [7:0]          aluop_i,
    input  logic                valid_i,
    input  logic [REG_SIZE-1:0] addr_i,
    input  logic [REG_SIZE-1:0] wdata_i,
    output logic                stall_o,
    output logic [REG_SIZE-1:0] rdata_o,
    output logic                rdata_valid_o,
    output logic                misalign_o,
    output logic                bus_error_o,
    mem_access_unit_if.master   mem
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    memState_e           state_q, state_d;
    logic [CNT_W-1:0]    timeoutCnt_q, timeoutCnt_d;
    logic                memReq_q, memReq_d;
    logic                memWe_q, memWe_d;
    logic [REG_SIZE-1:0] memAddr_q, memAddr_d;
    logic [3:0]          memBe_q, memBe_d;
    logic [REG_SIZE-1:0] memWdata_q, memWdata_d;
    logic [7:0]          op_q, op_d;
    logic [1:0]          lane_q, lane_d;
    logic [REG_SIZE-1:0] rdata_q, rdata_d;
    logic                rdataValid_q, rdataValid_d;
    logic                misalign_q, misalign_d;
    logic                busError_q, busError_d;

    logic                accept;
    logic                aligned;
    logic [REG_SIZE-1:0] loadData;

    // A new op is taken only when the unit is free; DONE counts as free so
    // back-to-back accesses lose no cycle.
    assign accept  = valid_i && isMemOp(aluop_i) &&
                     ((state_q == MEM_STATE_IDLE) || (state_q == MEM_STATE_DONE));
    assign aligned = !isWordOp(aluop_i) || (addr_i[1:0] == 2'b00);
    assign stall_o = !reset_i && ((accept && aligned) || (state_q == MEM_STATE_BUSY));

    assign mem.req       = memReq_q;
    assign mem.we        = memWe_q;
    assign mem.addr      = memAddr_q;
    assign mem.be        = memBe_q;
    assign mem.wdata     = memWdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdataValid_q;
    assign misalign_o    = misalign_q;
    assign bus_error_o   = busError_q;

    mem_access_unit_load_extract u_load_extract (
        .lane_i (lane_q),
        .op_i   (op_q),
        .word_i (mem.rdata),
        .data_o (loadData)
    );

    // Next-state logic: launch, hold, complete or abort the memory access.
    always_comb begin
        state_d      = state_q;
        timeoutCnt_d = timeoutCnt_q;
        memReq_d     = memReq_q;
        memWe_d      = memWe_q;
        memAddr_d    = memAddr_q;
        memBe_d      = memBe_q;
        memWdata_d   = memWdata_q;
        op_d         = op_q;
        lane_d       = lane_q;
        rdata_d      = rdata_q;
        rdataValid_d = 1'b0;
        misalign_d   = 1'b0;
        busError_d   = 1'b0;

        case (state_q)
            MEM_STATE_IDLE, MEM_STATE_DONE: begin
                state_d = MEM_STATE_IDLE;
                if (accept && aligned) begin
                    state_d      = MEM_STATE_BUSY;
                    timeoutCnt_d = '0;
                    memReq_d     = 1'b1;
                    memWe_d      = !isLoadOp(aluop_i);
                    memAddr_d    = {addr_i[REG_SIZE-1:2], 2'b00};
                    op_d         = aluop_i;
                    lane_d       = addr_i[1:0];
                    if (aluop_i == ALUOP_STB) begin
                        memBe_d    = BE_BYTE << addr_i[1:0];
                        memWdata_d = {(REG_SIZE/8){wdata_i[7:0]}};
                    end else if (aluop_i == ALUOP_STW) begin
                        memBe_d    = BE_WORD;
                        memWdata_d = wdata_i;
                    end else begin
                        memBe_d    = BE_WORD;
                        memWdata_d = '0;
                    end
                end else if (accept) begin
                    misalign_d = 1'b1;
                end
            end
            MEM_STATE_BUSY: begin
                if (mem.ack) begin
                    state_d      = MEM_STATE_DONE;
                    memReq_d     = 1'b0;
                    rdata_d      = isLoadOp(op_q) ? loadData : rdata_q;
                    rdataValid_d = isLoadOp(op_q);
                end else if (timeoutCnt_q == CNT_LAST) begin
                    state_d    = MEM_STATE_IDLE;
                    memReq_d   = 1'b0;
                    busError_d = 1'b1;
                end else begin
                    timeoutCnt_d = timeoutCnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = MEM_STATE_IDLE;
                memReq_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= MEM_STATE_IDLE;
            timeoutCnt_q <= '0;
            memReq_q     <= 1'b0;
            memWe_q      <= 1'b0;
            memAddr_q    <= '0;
            memBe_q      <= '0;
            memWdata_q   <= '0;
            op_q         <= '0;
            lane_q       <= '0;
            rdata_q      <= '0;
            rdataValid_q <= 1'b0;
            misalign_q   <= 1'b0;
            busError_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timeoutCnt_q <= timeoutCnt_d;
            memReq_q     <= memReq_d;
            memWe_q      <= memWe_d;
            memAddr_q    <= memAddr_d;
            memBe_q      <= memBe_d;
            memWdata_q   <= memWdata_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            rdata_q      <= rdata_d;
            rdataValid_q <= rdataValid_d;
            misalign_q   <= misalign_d;
            busError_q   <= busError_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected memory
// requests and result pulses, a monitor pops and compares as they appear.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  aluop = '0;
    logic        valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdataValid;
    logic        misalign;
    logic        busError;

    logic        respAck = 1'b0;
    logic        manualAck = 1'b0;
    logic [31:0] memWord = '0;
    int          ackDelay = 0;
    int          waitCnt = 0;
    bit          respDone = 1'b0;

    mem_access_unit_if memIf ();

    assign memIf.ack   = respAck | manualAck;
    assign memIf.rdata = memWord;

    mem_access_unit #(.TIMEOUT_CYCLES(64)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .aluop_i       (aluop),
        .valid_i       (valid),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .stall_o       (stall),
        .rdata_o       (rdata),
        .rdata_valid_o (rdataValid),
        .misalign_o    (misalign),
        .bus_error_o   (busError),
        .mem           (memIf)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_REQ = 0, EV_RDATA = 1, EV_MISALIGN = 2, EV_BUSERR = 3} evKind_e;
    typedef struct {
        evKind_e     kind;
        logic [31:0] data;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        bit          checkData;
    } ev_t;

    ev_t expQ[$];

    int  nChecks = 0;
    int  nPassed = 0;
    int  stallCount = 0;
    int  reqCycles = 0;
    int  rdValidSeen = 0;
    int  cycleCnt = 0;
    int  lastRdValidCycle = 0;
    int  lastReqGap = 0;
    bit  stableOk = 1'b1;
    logic        prevReq = 1'b0;
    logic [31:0] heldAddr, heldWdata;
    logic [3:0]  heldBe;
    logic        heldWe;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPassed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic pushReq(input logic [31:0] a, input logic [3:0] be, input logic we,
                           input logic [31:0] d, input bit chk);
        ev_t e;
        e.kind = EV_REQ; e.addr = a; e.be = be; e.we = we; e.data = d; e.checkData = chk;
        expQ.push_back(e);
    endtask

    task automatic pushEv(input evKind_e k, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.addr = '0; e.be = '0; e.we = 1'b0; e.data = d; e.checkData = 1'b0;
        expQ.push_back(e);
    endtask

    task automatic popAndCheck(input evKind_e k, input logic [31:0] d, input logic [31:0] a,
                               input logic [3:0] be, input logic we);
        ev_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpectedEvent", 32'(k), 32'hFFFF_FFFF);
        end else begin
            e = expQ.pop_front();
            checkOutput("eventKind", 32'(k), 32'(e.kind));
            if (k == e.kind) begin
                case (k)
                    EV_REQ: begin
                        checkOutput("reqAddr", a, e.addr);
                        checkOutput("reqBe", 32'(be), 32'(e.be));
                        checkOutput("reqWe", 32'(we), 32'(e.we));
                        if (e.checkData) checkOutput("reqWdata", d, e.data);
                    end
                    EV_RDATA: checkOutput("rdata", d, e.data);
                    default: ;
                endcase
            end
        end
    endtask

    // Monitor: samples between clock edges, counts stall/request cycles and
    // compares every observed event against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cycleCnt++;
            if (stall) stallCount++;
            if (memIf.req) reqCycles++;
            if (memIf.req && !prevReq) begin
                lastReqGap = cycleCnt - lastRdValidCycle;
                heldAddr = memIf.addr; heldBe = memIf.be; heldWe = memIf.we; heldWdata = memIf.wdata;
                stableOk = 1'b1;
                popAndCheck(EV_REQ, memIf.wdata, memIf.addr, memIf.be, memIf.we);
            end else if (memIf.req) begin
                if (memIf.addr !== heldAddr || memIf.be !== heldBe ||
                    memIf.we !== heldWe || memIf.wdata !== heldWdata) stableOk = 1'b0;
            end
            if (!memIf.req && prevReq) checkOutput("reqStable", 32'(stableOk), 32'd1);
            if (rdataValid) begin
                rdValidSeen++;
                lastRdValidCycle = cycleCnt;
                popAndCheck(EV_RDATA, rdata, '0, '0, 1'b0);
            end
            if (misalign) popAndCheck(EV_MISALIGN, '0, '0, '0, 1'b0);
            if (busError) popAndCheck(EV_BUSERR, '0, '0, '0, 1'b0);
            prevReq = memIf.req;
        end
    end

    // Memory model: acks after ackDelay request cycles (negative = never).
    initial begin
        forever begin
            @(negedge clk);
            if (memIf.req && !respDone && ackDelay >= 0 && waitCnt == ackDelay) begin
                respAck = 1'b1;
                respDone = 1'b1;
            end else begin
                respAck = 1'b0;
            end
            if (memIf.req) waitCnt++;
            else begin
                waitCnt = 0;
                respDone = 1'b0;
            end
        end
    end

    // Presents one instruction for a single cycle, starting at a falling edge.
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        aluop = op; addr = a; wdata = d; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; aluop = '0;
    endtask

    task automatic waitQuiet(input int limit);
        int n = 0;
        #1;
        while ((stall || memIf.req) && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("quietAfterOp", 32'({stall, memIf.req}), 32'd0);
        @(negedge clk);
    endtask

    task automatic runOp(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input int delay, input logic [31:0] word, input int expStall, input int expReq);
        ackDelay = delay;
        memWord = word;
        stallCount = 0;
        reqCycles = 0;
        applyStimulus(op, a, d);
        waitQuiet(200);
        checkOutput("stallCycles", stallCount, expStall);
        checkOutput("reqCycles", reqCycles, expReq);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rvBefore;
        repeat (2) @(negedge clk);
        checkOutput("resetReq", 32'(memIf.req), 32'd0);
        checkOutput("resetStall", 32'(stall), 32'd0);
        checkOutput("resetRdata", rdata, 32'd0);
        checkOutput("resetPulses", 32'({rdataValid, misalign, busError}), 32'd0);
        checkOutput("resetMemAddr", memIf.addr, 32'd0);
        checkOutput("resetMemBe", 32'(memIf.be), 32'd0);
        checkOutput("resetMemWdata", memIf.wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // LDW, ack in the first request cycle
        pushReq(32'h100, 4'b1111, 1'b0, '0, 1'b0);
        pushEv(EV_RDATA, 32'hDEADBEEF);
        runOp(ALUOP_LDW, 32'h100, '0, 0, 32'hDEADBEEF, 2, 1);

        // LDB lanes with sign extension
        pushReq(32'h100, 4'b1111, 1'b0, '0, 1'b0);
        pushEv(EV_RDATA, 32'hFFFFFF80);
        runOp(ALUOP_LDB, 32'h103, '0, 0, 32'h80112233, 2, 1);
        pushReq(32'h100, 4'b1111, 1'b0, '0, 1'b0);
        pushEv(EV_RDATA, 32'h00000022);
        runOp(ALUOP_LDB, 32'h101, '0, 0, 32'h80112233, 2, 1);
        pushReq(32'h100, 4'b1111, 1'b0, '0, 1'b0);
        pushEv(EV_RDATA, 32'hFFFFFFF1);
        runOp(ALUOP_LDB, 32'h102, '0, 1, 32'h00F10000, 3, 2);

        // STB with delayed ack: lane 2, replicated data, no result pulse
        pushReq(32'h200, 4'b0100, 1'b1, 32'hA5A5A5A5, 1'b1);
        runOp(ALUOP_STB, 32'h202, 32'h000000A5, 5, '0, 7, 6);

        // Misaligned STW: no access, misalign pulse, no stall
        pushEv(EV_MISALIGN, '0);
        runOp(ALUOP_STW, 32'h006, 32'h12345678, 0, '0, 0, 0);
        pushReq(32'h008, 4'b1111, 1'b0, '0, 1'b0);
        pushEv(EV_RDATA, 32'h12345678);
        runOp(ALUOP_LDW, 32'h008, '0, 0, 32'h12345678, 2, 1);

        // Aligned STW and a non-memory op
        pushReq(32'h30C, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b1);
        runOp(ALUOP_STW, 32'h30C, 32'hCAFEF00D, 2, '0, 4, 3);
        runOp(8'h01, 32'h104, 32'h55, 0, '0, 0, 0);

        // Back-to-back LDW: second op accepted in the DONE cycle
        ackDelay = 0;
        memWord = 32'h11111111;
        pushReq(32'h600, 4'b1111, 1'b0, '0, 1'b0);
        pushEv(EV_RDATA, 32'h11111111);
        pushReq(32'h604, 4'b1111, 1'b0, '0, 1'b0);
        pushEv(EV_RDATA, 32'h22222222);
        applyStimulus(ALUOP_LDW, 32'h600, '0);
        @(negedge clk);
        memWord = 32'h22222222;
        applyStimulus(ALUOP_LDW, 32'h604, '0);
        waitQuiet(20);
        checkOutput("b2bReqGap", lastReqGap, 32'd1);

        // Timeout: never acked
        pushReq(32'h400, 4'b1111, 1'b0, '0, 1'b0);
        pushEv(EV_BUSERR, '0);
        runOp(ALUOP_LDW, 32'h400, '0, -1, 32'h0BADF00D, 65, 64);

        // Reset in the middle of BUSY, then a late ack
        pushReq(32'h500, 4'b1111, 1'b0, '0, 1'b0);
        ackDelay = -1;
        memWord = 32'h5555AAAA;
        applyStimulus(ALUOP_LDW, 32'h500, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midResetReq", 32'(memIf.req), 32'd0);
        checkOutput("midResetStall", 32'(stall), 32'd0);
        checkOutput("midResetRdata", rdata, 32'd0);
        checkOutput("midResetMemAddr", memIf.addr, 32'd0);
        checkOutput("midResetMemBe", 32'(memIf.be), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rvBefore = rdValidSeen;
        @(negedge clk);
        manualAck = 1'b1;
        @(negedge clk);
        manualAck = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("lateAckRdValid", rdValidSeen - rvBefore, 32'd0);
        checkOutput("lateAckReq", 32'(memIf.req), 32'd0);

        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the effective address computed by the exec-stage ALU for ALUOP_LDB/LDW/STB/STW.
- Turns a memory aluop, address and store data into one request/acknowledge transaction on the data-memory port.
- Performs byte-lane steering and sign extension, and stalls the pipeline until the access completes.
- Also flags misaligned word accesses and memory timeouts.

Parameters:
- REG_SIZE, 32, datapath and address width; taken from `REG_SIZE in define.v.
- TIMEOUT_CYCLES, 64, number of cycles spent waiting for mem_ack before the unit aborts with bus_error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- aluop  in  8  operation from EX/MEM; only ALUOP_LDB/LDW/STB/STW start an access.
- valid  in  1  EX/MEM slot holds a live instruction.
- addr  in  REG_SIZE  effective address (ALU out).
- wdata  in  REG_SIZE  store data (rt value).
- stall  out  1  freeze the pipeline at or before MEM.
- rdata  out  REG_SIZE  load result, extended to full width.
- rdata_valid  out  1  one-cycle pulse; rdata is valid.
- misalign  out  1  one-cycle pulse; word access with addr[1:0]!=0.
- bus_error  out  1  one-cycle pulse; timeout abort.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  REG_SIZE  word-aligned address, {addr[31:2],2'b00}.
- mem_be  out  4  byte enables, little-endian.
- mem_wdata  out  REG_SIZE  write data.
- mem_ack  in  1  memory completes the request this cycle.
- mem_rdata  in  REG_SIZE  read word, valid when mem_ack=1.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - state=IDLE.
  - All outputs 0: rdata=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - Timeout counter=0.
  - A reset mid-transaction drops mem_req at once. A mem_ack arriving after reset is ignored.
- Accept condition: valid=1, aluop is a memory op, and state is IDLE or DONE.
- Alignment check:
  - LDW/STW with addr[1:0]!=0 do not access memory.
  - misalign is pulsed the following cycle; stall=0 throughout; state stays IDLE.
  - Byte ops are never misaligned.
- FSM states IDLE, BUSY, DONE:
  - IDLE/DONE to BUSY on an aligned accept. That edge registers mem_req=1, mem_we, mem_addr, mem_be and mem_wdata.
  - BUSY holds all mem_* outputs stable until mem_ack. On the mem_ack edge it goes to DONE and mem_req drops to 0.
  - DONE lasts one cycle and pulses rdata_valid for loads (stores pulse nothing). On its next edge it returns to IDLE, or to BUSY if a new op is accepted.
  - Any other state goes to IDLE.
- stall (combinational) = (accept && aligned) || state==BUSY. It is 0 in DONE, so the pipeline advances exactly one cycle after mem_ack.
- Minimum latency: accept cycle, then mem_req cycle with ack, then DONE. That is 3 cycles and 2 stall cycles.
- Byte lane: lane = addr[1:0], little-endian.
  - LDB: rdata = sign-extension of mem_rdata[8*lane+7 : 8*lane].
  - LDW: rdata = mem_rdata.
  - STB: mem_be = 4'b0001<<lane, mem_wdata = {4{wdata[7:0]}}.
  - STW: mem_be=4'b1111, mem_wdata=wdata.
  - Loads drive mem_be=4'b1111 and mem_we=0.
- Timeout:
  - The counter is cleared on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: go to IDLE, drop mem_req, pulse bus_error the next cycle, no rdata_valid.
  - An ack in that same cycle wins: normal completion.
- A mem_ack outside BUSY is ignored.
- Non-memory aluop, or valid=0: no effect, stall=0.

Decomposition:
- Shared package / define.v:
  - ALUOP_LDB/LDW/STB/STW codes and REG_SIZE, reused as is.
  - New constants MEM_STATE_IDLE/BUSY/DONE and BE_WORD=4'b1111.
- One natural combinational sub-module, load_extract: inputs lane, op and word; output is the extended rdata. It is reusable by a future LDBU/LDH.
- FSM, counter and registers stay in mem_access_unit.

Test Plan:
- LDW addr=0x100, memory acks in the first mem_req cycle with 0xDEADBEEF -> mem_addr=0x100, be=1111, we=0; stall high 2 cycles; rdata=0xDEADBEEF with rdata_valid in the DONE cycle.
- LDB addr=0x103, mem_rdata=0x80112233 -> rdata=0xFFFFFF80. LDB addr=0x101 on the same word -> rdata=0x00000022.
- STB addr=0x202 wdata=0x000000A5, ack delayed 5 cycles -> mem_be=0100, mem_wdata=0xA5A5A5A5, mem_* held stable 6 cycles, stall released in DONE, no rdata_valid.
- STW addr=0x006 -> no mem_req, misalign pulse, stall=0. A following LDW addr=0x008 proceeds normally.
- Never ack, TIMEOUT_CYCLES=64 -> mem_req high exactly 64 cycles, then bus_error pulse, state IDLE, stall=0.
- Assert reset in the middle of BUSY, then pulse mem_ack after release -> mem_req=0 immediately, all outputs 0, late ack produces no rdata_valid. Back-to-back LDW accepted in DONE -> second mem_req on the cycle after DONE.
